alu_ctrl_issue: RTL and testbench

EX-stage control block that drives the per-bit ALU slice array: decodes ALUOp/funct into the 3-bit slice operation code, B-invert and carry-in, and selects the EX result source. It also owns a 32-cycle sequential shift-add unsigned multiplier (MULTU) with HI/LO registers. A hazard interlock stalls the pipeline when MFHI, MFLO or a second MULTU reaches EX while a multiply is in flight.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_ctrl_issue_if.sv | 30 +++
 rtl/alu_ctrl_issue_mult_seq.sv | 72 +++++++
 rtl/alu_ctrl_issue.sv | 70 +++++++
 tb/tb_alu_ctrl_issue.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU control slice: slice op codes, funct
// fields, ALUOp and result-select encodings, and the multiplier FSM states.
package alu_pkg;

  localparam logic [2:0] SIG_AND = 3'b000;
  localparam logic [2:0] SIG_OR  = 3'b001;
  localparam logic [2:0] SIG_ADD = 3'b010;
  localparam logic [2:0] SIG_SUB = 3'b110;
  localparam logic [2:0] SIG_SLT = 3'b111;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_RSVD  = 2'b11;

  localparam logic [1:0] RSEL_ALU = 2'b00;
  localparam logic [1:0] RSEL_HI  = 2'b01;
  localparam logic [1:0] RSEL_LO  = 2'b10;

  typedef enum logic {IDLE, MUL} mul_state_t;

endpackage

// File: rtl/alu_ctrl_issue_if.sv
// EX-stage instruction/control bundle between the pipeline and alu_ctrl_issue.
interface alu_ctrl_issue_if #(
  parameter int unsigned WIDTH = 32
);
  logic             id_valid;
  logic             flush;
  logic [1:0]       alu_op;
  logic [5:0]       funct;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [2:0]       signal;
  logic             invert;
  logic             cin;
  logic [1:0]       result_sel;
  logic             bad_funct;
  logic             stall;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output id_valid, flush, alu_op, funct, rs_data, rt_data,
    input  signal, invert, cin, result_sel, bad_funct, stall, busy, hi, lo
  );

  modport slave (
    input  id_valid, flush, alu_op, funct, rs_data, rt_data,
    output signal, invert, cin, result_sel, bad_funct, stall, busy, hi, lo
  );
endinterface

// File: rtl/alu_ctrl_issue_mult_seq.sv
// Sequential shift-add unsigned multiplier: WIDTH iterations, HI/LO written
// together on the last iteration.
module mult_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] mcand_in,
  input  logic [WIDTH-1:0] mplier_in,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  mul_state_t       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   acc_next;
  logic [WIDTH-1:0] mplier_next;

  // The low bit of the sum shifts into the multiplier register as the
  // product's low half accumulates there.
  always_comb begin
    sum         = acc + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next    = {1'b0, sum[WIDTH:1]};
    mplier_next = {sum[0], mplier[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand  <= mcand_in;
          mplier <= mplier_in;
          acc    <= '0;
          cnt    <= '0;
          state  <= MUL;
        end
        MUL: begin
          acc    <= acc_next;
          mplier <= mplier_next;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            hi    <= acc_next[WIDTH-1:0];
            lo    <= mplier_next;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == MUL);

endmodule

// File: rtl/alu_ctrl_issue.sv
// EX-stage ALU control: slice op decode, result source select, MULTU issue
// and the HI/LO hazard interlock around the sequential multiplier.
module alu_ctrl_issue
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk,
  input logic             rst_n,
  alu_ctrl_issue_if.slave bus
);
  logic             rtype;
  logic             is_multu;
  logic             hilo_use;
  logic             accept;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  always_comb begin
    bus.signal     = SIG_AND;
    bus.result_sel = RSEL_ALU;
    bus.bad_funct  = 1'b0;
    case (bus.alu_op)
      ALUOP_MEM:   bus.signal = SIG_ADD;
      ALUOP_BR:    bus.signal = SIG_SUB;
      ALUOP_RTYPE: begin
        case (bus.funct)
          FN_ADD:   bus.signal = SIG_ADD;
          FN_SUB:   bus.signal = SIG_SUB;
          FN_AND:   bus.signal = SIG_AND;
          FN_OR:    bus.signal = SIG_OR;
          FN_SLT:   bus.signal = SIG_SLT;
          FN_MFHI:  bus.result_sel = RSEL_HI;
          FN_MFLO:  bus.result_sel = RSEL_LO;
          FN_MULTU: ;
          default:  bus.bad_funct = 1'b1;
        endcase
      end
      default:     bus.bad_funct = 1'b1;
    endcase
    bus.invert = (bus.signal == SIG_SUB) || (bus.signal == SIG_SLT);
    bus.cin    = bus.invert;
  end

  assign rtype    = (bus.alu_op == ALUOP_RTYPE);
  assign is_multu = rtype && (bus.funct == FN_MULTU);
  assign hilo_use = rtype && (bus.funct == FN_MULTU || bus.funct == FN_MFHI ||
                              bus.funct == FN_MFLO);

  // Only HI/LO consumers wait; a flushed instruction neither stalls nor issues.
  assign bus.stall = busy && bus.id_valid && !bus.flush && hilo_use;
  assign accept    = bus.id_valid && !bus.flush && !bus.stall && is_multu;

  mult_seq #(.WIDTH(WIDTH)) u_mult (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (accept),
    .mcand_in  (bus.rs_data),
    .mplier_in (bus.rt_data),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo)
  );

  assign bus.busy = busy;
  assign bus.hi   = hi;
  assign bus.lo   = lo;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Directed self-checking bench for alu_ctrl_issue: decode table, multiplier
// results and latency, HI/LO interlock, flush and asynchronous reset.
module tb_alu_ctrl_issue;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  alu_ctrl_issue_if #(.WIDTH(32)) bus ();

  alu_ctrl_issue #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] fn;
    logic [2:0] sig;
    logic       inv;
    logic       ci;
    logic       bad;
    logic [1:0] rsel;
  } dvec_t;

  dvec_t dtab [12] = '{
    '{2'b10, 6'b100000, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00},
    '{2'b10, 6'b100010, 3'b110, 1'b1, 1'b1, 1'b0, 2'b00},
    '{2'b10, 6'b100100, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00},
    '{2'b10, 6'b100101, 3'b001, 1'b0, 1'b0, 1'b0, 2'b00},
    '{2'b10, 6'b101010, 3'b111, 1'b1, 1'b1, 1'b0, 2'b00},
    '{2'b00, 6'b101010, 3'b010, 1'b0, 1'b0, 1'b0, 2'b00},
    '{2'b01, 6'b100100, 3'b110, 1'b1, 1'b1, 1'b0, 2'b00},
    '{2'b10, 6'b000111, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00},
    '{2'b11, 6'b100010, 3'b000, 1'b0, 1'b0, 1'b1, 2'b00},
    '{2'b10, 6'b010000, 3'b000, 1'b0, 1'b0, 1'b0, 2'b01},
    '{2'b10, 6'b010010, 3'b000, 1'b0, 1'b0, 1'b0, 2'b10},
    '{2'b10, 6'b011001, 3'b000, 1'b0, 1'b0, 1'b0, 2'b00}
  };

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic fl, input logic [1:0] op,
                       input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt);
    bus.id_valid = v;
    bus.flush    = fl;
    bus.alu_op   = op;
    bus.funct    = fn;
    bus.rs_data  = rs;
    bus.rt_data  = rt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 2'b00, 6'b000000, 32'h0, 32'h0);
  endtask

  // Returns the number of cycles busy stays high, bounded at 100.
  task automatic wait_busy(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    idle();
    step();
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL reset_state: busy=%b stall=%b hi=%h lo=%h, want 0/0/0/0",
               bus.busy, bus.stall, bus.hi, bus.lo);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_decode();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, dtab[i].op, dtab[i].fn, 32'h0, 32'h0);
      #1;
      checks++;
      if ({bus.signal, bus.invert, bus.cin, bus.bad_funct, bus.result_sel} !==
          {dtab[i].sig, dtab[i].inv, dtab[i].ci, dtab[i].bad, dtab[i].rsel}) begin
        errors++;
        $display("FAIL decode[%0d]: sig/inv/cin/bad/rsel=%b/%b/%b/%b/%b, want %b/%b/%b/%b/%b",
                 i, bus.signal, bus.invert, bus.cin, bus.bad_funct, bus.result_sel,
                 dtab[i].sig, dtab[i].inv, dtab[i].ci, dtab[i].bad, dtab[i].rsel);
      end
    end
    idle();
    step();
  endtask

  task automatic run_mult(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo);
    int n;
    drive(1'b1, 1'b0, ALUOP_RTYPE, FN_MULTU, a, b);
    step();
    idle();
    wait_busy(n);
    checks++;
    if (n != 32) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d, want 32", name, n);
    end
    checks++;
    if (bus.hi !== ehi || bus.lo !== elo) begin
      errors++;
      $display("FAIL %s_result: hi=%h lo=%h, want hi=%h lo=%h", name, bus.hi, bus.lo, ehi, elo);
    end
  endtask

  task automatic test_mult_values();
    run_mult("mult_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_mult("mult_7x6", 32'd7, 32'd6, 32'h0, 32'd42);
  endtask

  task automatic test_mfhi_interlock();
    int n;
    drive(1'b1, 1'b0, ALUOP_RTYPE, FN_MULTU, 32'h1234_5678, 32'h0000_0100);
    step();
    idle();
    step();
    // MFHI enters EX one cycle after the MULTU has left it.
    drive(1'b1, 1'b0, ALUOP_RTYPE, FN_MFHI, 32'h0, 32'h0);
    #1;
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      step();
    end
    checks++;
    if (n != 31) begin
      errors++;
      $display("FAIL mfhi_stall_cycles: got %0d, want 31", n);
    end
    checks++;
    if (bus.result_sel !== RSEL_HI || bus.hi !== 32'h0000_0012 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mfhi_release: rsel=%b hi=%h busy=%b, want 01/00000012/0",
               bus.result_sel, bus.hi, bus.busy);
    end
    idle();
    step();
  endtask

  task automatic test_back_to_back();
    int n;
    drive(1'b1, 1'b0, ALUOP_RTYPE, FN_MULTU, 32'd3, 32'd5);
    step();
    drive(1'b1, 1'b0, ALUOP_RTYPE, FN_MULTU, 32'h8000_0000, 32'd2);
    #1;
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      step();
    end
    checks++;
    if (n != 32 || bus.busy !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'd15) begin
      errors++;
      $display("FAIL b2b_first: stalls=%0d busy=%b hi=%h lo=%h, want 32/0/0/0000000f",
               n, bus.busy, bus.hi, bus.lo);
    end
    step();
    idle();
    wait_busy(n);
    checks++;
    if (n != 32 || bus.hi !== 32'h1 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL b2b_second: busy_cycles=%0d hi=%h lo=%h, want 32/00000001/00000000",
               n, bus.hi, bus.lo);
    end
  endtask

  task automatic test_flush();
    int n;
    drive(1'b1, 1'b1, ALUOP_RTYPE, FN_MULTU, 32'd9, 32'd9);
    step();
    idle();
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'h1 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL flush_no_accept: busy=%b hi=%h lo=%h, want 0/00000001/00000000",
               bus.busy, bus.hi, bus.lo);
    end
    drive(1'b1, 1'b0, ALUOP_RTYPE, FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    step();
    idle();
    step();
    step();
    drive(1'b1, 1'b1, ALUOP_RTYPE, FN_MFLO, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.stall !== 1'b0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_masks_stall: stall=%b busy=%b, want 0/1", bus.stall, bus.busy);
    end
    step();
    idle();
    wait_busy(n);
    checks++;
    if (n != 29 || bus.hi !== 32'hFFFF_FFFE || bus.lo !== 32'h1) begin
      errors++;
      $display("FAIL flush_during_busy: remaining=%0d hi=%h lo=%h, want 29/fffffffe/00000001",
               n, bus.hi, bus.lo);
    end
  endtask

  task automatic test_reset_mid_mult();
    drive(1'b1, 1'b0, ALUOP_RTYPE, FN_MULTU, 32'h0000_1234, 32'h0000_0010);
    step();
    idle();
    for (int i = 0; i < 10; i++) step();
    drive(1'b1, 1'b0, ALUOP_RTYPE, FN_MFHI, 32'h0, 32'h0);
    #1;
    checks++;
    if (bus.stall !== 1'b1 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_stall: stall=%b busy=%b, want 1/1", bus.stall, bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 || bus.hi !== 32'h0 || bus.lo !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: busy=%b stall=%b hi=%h lo=%h, want 0/0/0/0",
               bus.busy, bus.stall, bus.hi, bus.lo);
    end
    idle();
    step();
    rst_n = 1'b1;
    step();
    run_mult("post_reset", 32'd7, 32'd6, 32'h0, 32'd42);
  endtask

  initial begin
    idle();
    test_reset();
    test_decode();
    test_mult_values();
    test_mfhi_interlock();
    test_back_to_back();
    test_flush();
    test_reset_mid_mult();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
